// File: rtl/uart_tx.sv
// Wishbone-attached UART transmitter: byte FIFO feeding an 8N1 serial framer.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11-bit frames).
`ifndef SEL_WIDTH
`define SEL_WIDTH 4
`endif
`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 32
`endif

module uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    uart_tx_stb_i,
  input  logic                    uart_tx_cyc_i,
  input  logic                    uart_tx_we_i,
  input  logic [`SEL_WIDTH-1:0]   uart_tx_sel_i,
  input  logic [`ADR_WIDTH-1:0]   uart_tx_adr_i,
  input  logic [`DAT_WIDTH-1:0]   uart_tx_dat_i,
  output logic [`DAT_WIDTH-1:0]   uart_tx_dat_o,
  output logic                    uart_tx_ack_o,
  output logic                    uart_tx_err_o,
  output logic                    tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_LOAD = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [7:0]            fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  full_s, empty_s, push_s, pop_s, access_s, busy_s;
  state_t                state_r;
  logic [15:0]           baud_r;
  logic [2:0]            bit_idx_r;
  logic [7:0]            shift_r;
`ifdef UART_TX_PARITY_EN
  logic                  par_r;
`endif
  logic                  tx_r, ack_r, err_r, ack_s, err_s;
  logic [`DAT_WIDTH-1:0] dat_r, dat_s, status_s;
  logic                  unused_s;

  assign full_s   = (count_r == CW'(FIFO_DEPTH));
  assign empty_s  = (count_r == {CW{1'b0}});
  assign busy_s   = (state_r != ST_IDLE);
  assign access_s = uart_tx_cyc_i & uart_tx_stb_i & ~(ack_r | err_r);
  // The framer takes the head byte when leaving IDLE or at the end of a stop bit.
  assign pop_s    = ~empty_s & ((state_r == ST_IDLE) |
                                ((state_r == ST_STOP) & (baud_r == 16'd0)));
  assign unused_s = ^{uart_tx_sel_i, uart_tx_adr_i, uart_tx_dat_i};

  assign uart_tx_dat_o = dat_r;
  assign uart_tx_ack_o = ack_r;
  assign uart_tx_err_o = err_r;
  assign tx_o          = tx_r;

  // Status word assembly
  always_comb begin
    status_s       = {`DAT_WIDTH{1'b0}};
    status_s[0]    = full_s;
    status_s[1]    = empty_s;
    status_s[2]    = busy_s;
    status_s[14:8] = 7'(count_r);
  end

  // Register decode and termination select
  always_comb begin
    ack_s  = 1'b0;
    err_s  = 1'b0;
    dat_s  = {`DAT_WIDTH{1'b0}};
    push_s = 1'b0;
    if (access_s) begin
      case (uart_tx_adr_i[3:2])
        2'd0: begin
          if (!uart_tx_we_i) begin
            err_s = 1'b1;
          end else if (!uart_tx_sel_i[0]) begin
            ack_s = 1'b1;
          end else if (full_s) begin
            err_s = 1'b1;
          end else begin
            push_s = 1'b1;
            ack_s  = 1'b1;
          end
        end
        2'd1: begin
          if (uart_tx_we_i) begin
            err_s = 1'b1;
          end else begin
            ack_s = 1'b1;
            dat_s = status_s;
          end
        end
        default: err_s = 1'b1;
      endcase
    end else begin
      ack_s = 1'b0;
      err_s = 1'b0;
    end
  end

  // Bus termination registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      dat_r <= {`DAT_WIDTH{1'b0}};
    end else begin
      ack_r <= ack_s;
      err_r <= err_s;
      dat_r <= dat_s;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= uart_tx_dat_i[7:0];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Serial framer; tx_r is decoded from the previous cycle's state so it never glitches
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      baud_r    <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
`endif
      tx_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE:  tx_r <= 1'b1;
        ST_START: tx_r <= 1'b0;
        ST_DATA:  tx_r <= shift_r[0];
`ifdef UART_TX_PARITY_EN
        ST_PARITY: tx_r <= par_r;
`endif
        ST_STOP:  tx_r <= 1'b1;
        default:  tx_r <= 1'b1;
      endcase

      if (pop_s) begin
        state_r <= ST_START;
        baud_r  <= BAUD_LOAD;
        shift_r <= fifo_mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
        par_r   <= even_parity(fifo_mem_r[rd_ptr_r]);
`endif
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_START: begin
            if (baud_r == 16'd0) begin
              state_r   <= ST_DATA;
              baud_r    <= BAUD_LOAD;
              bit_idx_r <= 3'd0;
            end else begin
              baud_r <= baud_r - 16'd1;
            end
          end
          ST_DATA: begin
            if (baud_r == 16'd0) begin
              baud_r  <= BAUD_LOAD;
              shift_r <= {1'b0, shift_r[7:1]};
              if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_r <= ST_PARITY;
`else
                state_r <= ST_STOP;
`endif
              end else begin
                bit_idx_r <= bit_idx_r + 3'd1;
              end
            end else begin
              baud_r <= baud_r - 16'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            if (baud_r == 16'd0) begin
              state_r <= ST_STOP;
              baud_r  <= BAUD_LOAD;
            end else begin
              baud_r <= baud_r - 16'd1;
            end
          end
`endif
          ST_STOP: begin
            if (baud_r == 16'd0) begin
              state_r <= ST_IDLE;
            end else begin
              baud_r <= baud_r - 16'd1;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: bus responses and serial frames are checked
// by independent monitors against queues filled when stimulus is issued.
module tb_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_w = 32'h0;
  logic [31:0] dat_o;
  logic        ack_o, err_o, tx_o;

  uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .uart_tx_stb_i(stb), .uart_tx_cyc_i(cyc), .uart_tx_we_i(we),
    .uart_tx_sel_i(sel), .uart_tx_adr_i(adr), .uart_tx_dat_i(dat_w),
    .uart_tx_dat_o(dat_o), .uart_tx_ack_o(ack_o), .uart_tx_err_o(err_o),
    .tx_o(tx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0, n_bad = 0;
  int cyc_cnt = 0;
  int term_cyc = 0;
  int n_frames = 0;
  int start_cyc [64];
  logic mon_busy = 1'b0;
  logic [32:0] resp_q [$];
  logic [7:0]  byte_q [$];

  initial forever begin
    @(posedge clk_i);
    cyc_cnt = cyc_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wishbone master: holds the strobe until a termination is seen.
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic exp_err, input logic [31:0] exp_dat);
    bit got = 0;
    resp_q.push_back({exp_err, exp_dat});
    @(negedge clk_i);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk_i); #1;
      if (ack_o || err_o) begin
        got = 1;
        term_cyc = cyc_cnt;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; dat_w = 32'h0; sel = 4'h0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL bus_timeout: got no termination expected one at adr 0x%08h", a);
      void'(resp_q.pop_back());
    end
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_err);
    if (!exp_err) byte_q.push_back(b);
    wb(1'b1, 32'h0, {24'h0, b}, 4'hF, exp_err, 32'h0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while ((n_frames < n || mon_busy) && k < budget) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (k >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", n_frames, n);
    end
  endtask

  // Bus response monitor
  logic [32:0] e_resp;
  initial forever begin
    @(posedge clk_i); #1;
    if (ack_o || err_o) begin
      n_cmp++;
      if (resp_q.size() == 0) begin
        n_bad++;
        $display("FAIL bus_unexpected: got ack=%b err=%b expected no termination", ack_o, err_o);
      end else begin
        e_resp = resp_q.pop_front();
        if ((ack_o && err_o) || (err_o !== e_resp[32]) || (dat_o !== e_resp[31:0])) begin
          n_bad++;
          $display("FAIL bus_resp: got ack=%b err=%b dat=0x%08h expected err=%b dat=0x%08h",
                   ack_o, err_o, dat_o, e_resp[32], e_resp[31:0]);
        end
      end
    end else if (dat_o !== 32'h0) begin
      n_cmp++; n_bad++;
      $display("FAIL dat_idle: got 0x%08h expected 0x00000000", dat_o);
    end
  end

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    else if (k == 9) return ^b;
`endif
    else return 1'b1;
  endfunction

  // Serial monitor: checks every cycle of each frame against the expected byte
  logic prev_tx = 1'b1;
  logic [7:0] eb;
  bit fbad, fabort;
  int fbad_c;
  logic fbad_got;
  initial forever begin
    @(posedge clk_i); #1;
    if (rst_i && prev_tx === 1'b1 && tx_o === 1'b0) begin
      start_cyc[n_frames] = cyc_cnt;
      n_frames++;
      mon_busy = 1'b1;
      if (byte_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL serial_unexpected: got a start bit expected an idle line");
        eb = 8'h00;
      end else begin
        eb = byte_q.pop_front();
      end
      fbad = 0; fabort = 0; fbad_c = 0; fbad_got = 1'b0;
      for (int c = 0; c < NB * CLK_DIV; c++) begin
        if (c > 0) begin @(posedge clk_i); #1; end
        if (!rst_i) begin fabort = 1; break; end
        if (!fbad && tx_o !== fbit(eb, c / CLK_DIV)) begin
          fbad = 1; fbad_c = c; fbad_got = tx_o;
        end
      end
      if (!fabort) begin
        n_cmp++;
        if (fbad) begin
          n_bad++;
          $display("FAIL serial_frame byte 0x%02h cycle %0d: got tx=%b expected %b",
                   eb, fbad_c, fbad_got, fbit(eb, fbad_c / CLK_DIV));
        end
      end
      mon_busy = 1'b0;
    end
    prev_tx = tx_o;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run expected $finish");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

  int f, s, t, ack_c;
  initial begin
    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_tx", {31'h0, tx_o}, 32'h1);
    chk("rst_ack", {31'h0, ack_o}, 32'h0);
    chk("rst_err", {31'h0, err_o}, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Single byte 0x55, start-edge latency, idle status afterwards
    wb(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0000_0002);
    f = n_frames;
    wr_byte(8'h55, 1'b0);
    ack_c = term_cyc;
    wait_frames(f + 1, 200);
    chk("start_latency", 32'(start_cyc[f] - ack_c), 32'd2);
    repeat (4) @(posedge clk_i);
    wb(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0000_0002);

    // Parity vectors, sel[0]=0 write, illegal accesses leave the count alone
    f = n_frames;
    wr_byte(8'h07, 1'b0);
    wr_byte(8'h03, 1'b0);
    wr_byte(8'hA5, 1'b0);
    wb(1'b1, 32'h0, 32'h0000_00AA, 4'hE, 1'b0, 32'h0);
    wb(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'h0);
    wb(1'b1, 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    wb(1'b0, 32'h8, 32'h0, 4'hF, 1'b1, 32'h0);
    wb(1'b1, 32'hC, 32'h0000_0011, 4'hF, 1'b1, 32'h0);
    wb(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0000_0204);
    wait_frames(f + 3, 600);
    repeat (4) @(posedge clk_i);

    // Ten back-to-back writes into an 8-deep FIFO: the tenth overflows
    f = n_frames;
    for (int i = 0; i < 10; i++) wr_byte(8'(i), (i == 9));
    wb(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0000_0805);
    wait_frames(f + 9, 2000);
    for (int i = 0; i < 8; i++)
      chk("frame_gap", 32'(start_cyc[f+i+1] - start_cyc[f+i]), 32'(NB * CLK_DIV));
    repeat (4) @(posedge clk_i);

    // Push lands on the same edge as the framer's pop with count=3
    f = n_frames;
    wr_byte(8'h11, 1'b0);
    wr_byte(8'h22, 1'b0);
    wr_byte(8'h33, 1'b0);
    wr_byte(8'h44, 1'b0);
    s = start_cyc[f];
    t = s - 1 + NB * CLK_DIV;
    while (cyc_cnt < t - 1) begin @(posedge clk_i); #1; end
    wr_byte(8'h66, 1'b0);
    chk("push_pop_edge", 32'(term_cyc), 32'(t));
    wb(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0000_0304);
    wait_frames(f + 5, 1000);
    repeat (4) @(posedge clk_i);

    // Reset during data bit 3 aborts the frame
    f = n_frames;
    wr_byte(8'h00, 1'b0);
    for (int k = 0; k < 20 && n_frames <= f; k++) begin @(posedge clk_i); #1; end
    s = start_cyc[f];
    while (cyc_cnt < s + 4 + 3 * CLK_DIV + 1) begin @(posedge clk_i); #1; end
    chk("bit3_low", {31'h0, tx_o}, 32'h0);
    #1 rst_i = 1'b0;
    #1 chk("rst_async_tx", {31'h0, tx_o}, 32'h1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    wb(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, 32'h0000_0002);
    repeat (60) @(posedge clk_i);
    #1;
    chk("no_frame_after_rst", 32'(n_frames), 32'(f + 1));
    chk("idle_tx", {31'h0, tx_o}, 32'h1);

    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
    chk("byte_q_drained", 32'(byte_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
